cv32e40p_hwloop_unit: RTL

- Parametrised hardware-loop register file and loop-end controller for N_HWLP loops; generalises the fixed two-loop scheme.
- Sits beside the ID stage. CSR/lp.* setup writes the start, end and count registers. Each instruction leaving ID is compared against all loop ends.
- Produces a same-cycle branch request to the loop start and handles nested loops that share an end address (all exiting inner loops retire in one step).

---
 rtl/cv32e40p_localparam_pkg.sv | 20 ++
 rtl/cv32e40p_hwloop_sel.sv | 41 ++++
 rtl/cv32e40p_hwloop_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/cv32e40p_localparam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_localparam_pkg
// Brief    : Shared hardware-loop defaults, write-enable encoding and types.
// Revision : 1.0
// ============================================================================
package cv32e40p_localparam_pkg;

  localparam int N_HWLP      = 2;
  localparam int N_HWLP_BITS = 1;

  // Bit positions within the hardware-loop write-enable vector
  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  typedef logic [2:0] hwlp_we_t;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_hwloop_sel.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_hwloop_sel
// Brief    : Priority walk over matched loops, innermost (index 0) first.
// Revision : 1.0
// ============================================================================
module cv32e40p_hwloop_sel #(
  parameter int N_HWLP      = 2,
  parameter int N_HWLP_BITS = 1
) (
  input  logic [N_HWLP-1:0]      match,
  input  logic [N_HWLP-1:0]      cnt_one,
  output logic [N_HWLP-1:0]      exit_mask,
  output logic                   jump_valid,
  output logic [N_HWLP_BITS-1:0] jump_idx
);

  logic w_done;

  // Matched loops on their last iteration retire; the first one still
  // iterating takes the branch and shields every outer loop.
  always_comb begin
    exit_mask  = '0;
    jump_valid = 1'b0;
    jump_idx   = '0;
    w_done     = 1'b0;
    for (int i = 0; i < N_HWLP; i++) begin
      if (!w_done && match[i]) begin
        if (cnt_one[i]) begin
          exit_mask[i] = 1'b1;
        end else begin
          jump_valid = 1'b1;
          jump_idx   = N_HWLP_BITS'(i);
          w_done     = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cv32e40p_hwloop_unit.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_hwloop_unit
// Brief    : Parametrised hardware-loop register file and loop-end controller.
// Revision : 1.0
// ============================================================================
module cv32e40p_hwloop_unit #(
  parameter int N_HWLP      = 2,
  parameter int N_HWLP_BITS = (N_HWLP > 1) ? $clog2(N_HWLP) : 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   hwlp_we_i,
  input  logic [N_HWLP_BITS-1:0]       hwlp_regid_i,
  input  logic [ADDR_WIDTH-1:0]        hwlp_start_data_i,
  input  logic [ADDR_WIDTH-1:0]        hwlp_end_data_i,
  input  logic [ADDR_WIDTH-1:0]        hwlp_cnt_data_i,
  input  logic [ADDR_WIDTH-1:0]        id_pc_i,
  input  logic                         id_valid_i,
  input  logic                         id_ready_i,
  output logic                         hwlp_jump_o,
  output logic [ADDR_WIDTH-1:0]        hwlp_target_o,
  output logic [N_HWLP-1:0]            hwlp_active_o,
  output logic [N_HWLP*ADDR_WIDTH-1:0] hwlp_start_o,
  output logic [N_HWLP*ADDR_WIDTH-1:0] hwlp_end_o,
  output logic [N_HWLP*ADDR_WIDTH-1:0] hwlp_cnt_o
);

  import cv32e40p_localparam_pkg::*;

  logic [ADDR_WIDTH-1:0]  r_start [N_HWLP];
  logic [ADDR_WIDTH-1:0]  r_end   [N_HWLP];
  logic [ADDR_WIDTH-1:0]  r_cnt   [N_HWLP];

  hwlp_we_t               w_we;
  logic                   w_fire;
  logic [N_HWLP-1:0]      w_sel;
  logic [N_HWLP-1:0]      w_match;
  logic [N_HWLP-1:0]      w_cnt_one;
  logic [N_HWLP-1:0]      w_dec;
  logic [N_HWLP-1:0]      w_exit_mask;
  logic                   w_jump_valid;
  logic [N_HWLP_BITS-1:0] w_jump_idx;
  logic                   w_unused_lsb;

  assign w_we         = hwlp_we_i;
  assign w_fire       = id_valid_i & id_ready_i;
  assign w_unused_lsb = hwlp_start_data_i[0] ^ hwlp_end_data_i[0];

  // Out-of-range regids never equal any loop index, so they write nothing.
  for (genvar i = 0; i < N_HWLP; i++) begin : g_loop
    assign w_sel[i]     = (hwlp_regid_i == N_HWLP_BITS'(i));
    assign w_match[i]   = id_valid_i && (id_pc_i == r_end[i]) && (r_cnt[i] != '0);
    assign w_cnt_one[i] = (r_cnt[i] == ADDR_WIDTH'(1));
    assign w_dec[i]     = w_fire && (w_exit_mask[i] ||
                          (w_jump_valid && (w_jump_idx == N_HWLP_BITS'(i))));

    assign hwlp_active_o[i]                           = (r_cnt[i] != '0);
    assign hwlp_start_o[i*ADDR_WIDTH +: ADDR_WIDTH]   = r_start[i];
    assign hwlp_end_o[i*ADDR_WIDTH +: ADDR_WIDTH]     = r_end[i];
    assign hwlp_cnt_o[i*ADDR_WIDTH +: ADDR_WIDTH]     = r_cnt[i];
  end

  cv32e40p_hwloop_sel #(
    .N_HWLP      (N_HWLP),
    .N_HWLP_BITS (N_HWLP_BITS)
  ) u_sel (
    .match      (w_match),
    .cnt_one    (w_cnt_one),
    .exit_mask  (w_exit_mask),
    .jump_valid (w_jump_valid),
    .jump_idx   (w_jump_idx)
  );

  assign hwlp_jump_o   = w_jump_valid;
  assign hwlp_target_o = w_jump_valid ? r_start[w_jump_idx] : '0;

  // An exiting loop sits at 1, so a plain decrement retires it to 0.
  // A count write on the same loop takes precedence over its decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_HWLP; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_HWLP; i++) begin
        if (w_we[HWLP_WE_START] && w_sel[i])
          r_start[i] <= {hwlp_start_data_i[ADDR_WIDTH-1:1], 1'b0};
        if (w_we[HWLP_WE_END] && w_sel[i])
          r_end[i] <= {hwlp_end_data_i[ADDR_WIDTH-1:1], 1'b0};
        if (w_we[HWLP_WE_CNT] && w_sel[i])
          r_cnt[i] <= hwlp_cnt_data_i;
        else if (w_dec[i])
          r_cnt[i] <= r_cnt[i] - ADDR_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire
